// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit sample path: sample size encoding
// and per-size lane bookkeeping used by the TX unpacker.
package i2s_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SIZE_8  = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_32 = 2'b10
  } size_e;

  // cfg_size encodings 2'b10 and 2'b11 both select full-word samples.
  function automatic size_e decode_size(input logic [1:0] cfg);
    if (cfg[1]) return SIZE_32;
    else if (cfg[0]) return SIZE_16;
    else return SIZE_8;
  endfunction

  function automatic logic [2:0] lanes_per_word(input size_e size);
    case (size)
      SIZE_8:  return 3'd4;
      SIZE_16: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [1:0] last_lane(input size_e size);
    case (size)
      SIZE_8:  return 2'd3;
      SIZE_16: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/i2s_tx_unpacker.sv
// Splits packed FIFO words into right-aligned 8/16/32-bit samples for the I2S
// TX channel, sends silence on empty pulls and counts underruns.
module i2s_tx_unpacker
  import i2s_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             sck_i,
  input  logic             rstn_i,
  input  logic [31:0]      in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [31:0]      out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             cfg_en_i,
  input  logic [1:0]       cfg_size_i,
  input  logic             cfg_sext_i,
  output logic             err_underrun_o,
  output logic [CNT_W-1:0] underrun_cnt_o,
  output logic             busy_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  size_e              size;
  logic               load;
  logic               last;
  logic               accept;
  logic               underrun;
  logic [WORD_W-1:0]  sample;
  logic signed [7:0]  lane8;
  logic signed [15:0] lane16;

  logic [WORD_W-1:0]  r_word;
  logic               r_full;
  logic [1:0]         r_lane;
  logic [WORD_W-1:0]  r_out;
  logic               r_out_valid;
  logic               r_primed;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  assign size   = decode_size(cfg_size_i);
  assign last   = (r_lane == last_lane(size));
  assign load   = cfg_en_i & r_full & (!r_out_valid | out_ready_i);
  // Word register refills in the same cycle its last lane moves out.
  assign in_ready_o = rstn_i & cfg_en_i & (!r_full | (load & last));
  assign accept     = in_valid_i & in_ready_o;
  assign underrun   = r_primed & cfg_en_i & out_ready_i & !r_out_valid;

  always_comb begin
    lane8  = r_word[{r_lane, 3'b000} +: 8];
    lane16 = r_word[{r_lane[0], 4'b0000} +: 16];
    sample = r_word;
    case (size)
      SIZE_8:  sample = cfg_sext_i ? {{24{lane8[7]}}, lane8} : {24'd0, lane8};
      SIZE_16: sample = cfg_sext_i ? {{16{lane16[15]}}, lane16} : {16'd0, lane16};
      default: sample = r_word;
    endcase
  end

  // ---- stage p0: word register ----
  always_ff @(posedge sck_i) begin
    if (!rstn_i || !cfg_en_i) begin
      r_full <= 1'b0;
      r_lane <= 2'd0;
    end else begin
      if (load) begin
        r_lane <= last ? 2'd0 : r_lane + 2'd1;
        if (last) r_full <= 1'b0;
      end
      if (accept) r_full <= 1'b1;
    end
  end

  always_ff @(posedge sck_i) begin
    if (accept) r_word <= in_data_i;
  end

  // ---- stage p1: output register ----
  always_ff @(posedge sck_i) begin
    if (!rstn_i || !cfg_en_i) r_out_valid <= 1'b0;
    else if (load)            r_out_valid <= 1'b1;
    else if (out_ready_i)     r_out_valid <= 1'b0;
  end

  always_ff @(posedge sck_i) begin
    if (load) r_out <= sample;
  end

  // ---- underrun tracking, armed by the first real transfer ----
  always_ff @(posedge sck_i) begin
    if (!rstn_i || !cfg_en_i)           r_primed <= 1'b0;
    else if (r_out_valid && out_ready_i) r_primed <= 1'b1;
  end

  always_ff @(posedge sck_i) begin
    if (!rstn_i) r_err <= 1'b0;
    else         r_err <= underrun;
  end

  always_ff @(posedge sck_i) begin
    if (!rstn_i || !cfg_en_i) r_cnt <= '0;
    else if (underrun)        r_cnt <= sat_inc(r_cnt);
  end

  assign out_data_o     = r_out_valid ? r_out : '0;
  assign out_valid_o    = r_out_valid;
  assign err_underrun_o = r_err;
  assign underrun_cnt_o = r_cnt;
  assign busy_o         = r_full | r_out_valid;

endmodule

// File: tb/tb_i2s_tx_unpacker.sv
// Directed bench for i2s_tx_unpacker: lane table, 32-bit streaming,
// backpressure scoreboard, underrun/saturation and flush sequences.
module tb_i2s_tx_unpacker;

  logic        sck = 1'b0;
  logic        rstn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_en;
  logic [1:0]  cfg_size;
  logic        cfg_sext;
  logic        err;
  logic [1:0]  ucnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 sck = ~sck;

  i2s_tx_unpacker #(.CNT_W(2)) dut (
    .sck_i          (sck),
    .rstn_i         (rstn),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .cfg_en_i       (cfg_en),
    .cfg_size_i     (cfg_size),
    .cfg_sext_i     (cfg_sext),
    .err_underrun_o (err),
    .underrun_cnt_o (ucnt),
    .busy_o         (busy)
  );

  typedef struct {
    logic [1:0]       size;
    logic             sext;
    logic [31:0]      word;
    int               n;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic mid();
    @(negedge sck);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    mid();
    while (!in_ready && n < 20) begin
      tick();
      mid();
      n++;
    end
    chk("send_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, output logic [3:0][31:0] s);
    int got;
    int cyc;
    s = '0;
    got = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (got < n && cyc < 40) begin
      mid();
      if (out_valid) begin
        s[got] = out_data;
        got++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("collect_count", got, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][31:0] s;
    logic [31:0]      words[8];
    logic [31:0]      q[$];
    logic [31:0]      cur;
    logic [31:0]      held;
    logic [31:0]      fl_exp[2];
    logic             stalled;
    logic             acc;
    int               wi;
    int               oi;
    int               got;

    vecs[0] = '{2'b00, 1'b0, 32'h80FF7F01, 4, {32'h80, 32'hFF, 32'h7F, 32'h01}};
    vecs[1] = '{2'b01, 1'b1, 32'h80017FFF, 2, {32'h0, 32'h0, 32'hFFFF8001, 32'h00007FFF}};
    vecs[2] = '{2'b00, 1'b1, 32'h80FF7F01, 4, {32'hFFFFFF80, 32'hFFFFFFFF, 32'h7F, 32'h01}};
    vecs[3] = '{2'b01, 1'b0, 32'h80017FFF, 2, {32'h0, 32'h0, 32'h00008001, 32'h00007FFF}};
    vecs[4] = '{2'b10, 1'b1, 32'h80000001, 1, {32'h0, 32'h0, 32'h0, 32'h80000001}};
    vecs[5] = '{2'b11, 1'b0, 32'hDEADBEEF, 1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}};
    vecs[6] = '{2'b00, 1'b1, 32'h7F80017E, 4, {32'h7F, 32'hFFFFFF80, 32'h01, 32'h7E}};

    // reset asserted with enable and input activity present
    rstn      = 1'b0;
    cfg_en    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5A5A5;
    out_ready = 1'b1;
    cfg_size  = 2'b00;
    cfg_sext  = 1'b0;
    repeat (2) tick();
    mid();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_cnt",       {30'd0, ucnt},      32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    tick();
    rstn      = 1'b1;
    cfg_en    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    // lane extraction table
    for (int i = 0; i < 7; i++) begin
      cfg_en = 1'b0;
      tick();
      cfg_size = vecs[i].size;
      cfg_sext = vecs[i].sext;
      cfg_en   = 1'b1;
      send_word(vecs[i].word);
      collect(vecs[i].n, s);
      for (int l = 0; l < vecs[i].n; l++)
        chk($sformatf("vec%0d_lane%0d", i, l), s[l], vecs[i].exp[l]);
      mid();
      chk($sformatf("vec%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // 32-bit streaming: no bubbles, in_ready continuously high
    cfg_en = 1'b0;
    tick();
    cfg_size = 2'b10;
    cfg_sext = 1'b0;
    cfg_en   = 1'b1;
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    wi = 0;
    oi = 0;
    in_valid  = 1'b1;
    in_data   = words[0];
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && oi < 8; cyc++) begin
      mid();
      if (in_valid) chk("s32_in_ready", {31'd0, in_ready}, 32'd1);
      if (out_valid) begin
        chk($sformatf("s32_data%0d", oi), out_data, words[oi]);
        oi++;
      end else if (oi > 0) begin
        chk("s32_no_bubble", {31'd0, out_valid}, 32'd1);
      end
      acc = in_valid & in_ready;
      tick();
      if (acc) begin
        wi++;
        if (wi == 8) in_valid = 1'b0;
        else         in_data  = words[wi];
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("s32_count", oi, 8);

    // 8-bit mode, 100 words under random backpressure
    cfg_en = 1'b0;
    tick();
    cfg_size = 2'b00;
    cfg_sext = 1'b0;
    cfg_en   = 1'b1;
    wi = 0;
    got = 0;
    stalled = 1'b0;
    held = '0;
    cur = $urandom;
    for (int cyc = 0; cyc < 3000 && got < 400; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (wi < 100);
      in_data   = cur;
      mid();
      if (stalled) begin
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_data",  out_data, held);
      end
      if (in_valid && in_ready) begin
        for (int l = 0; l < 4; l++) q.push_back({24'd0, cur[8*l +: 8]});
        wi++;
        cur = $urandom;
      end
      if (out_valid && out_ready) begin
        if (q.size() > 0) chk("bp_sample", out_data, q.pop_front());
        else              chk("bp_unexpected", {31'd0, out_valid}, 32'd0);
        got++;
      end
      stalled = out_valid & !out_ready;
      held    = out_data;
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_count", got, 400);
    chk("bp_leftover", q.size(), 0);

    // underrun after priming; 2-bit counter saturates on the 4th pull
    cfg_en = 1'b0;
    tick();
    cfg_en = 1'b1;
    send_word(32'h11223344);
    collect(4, s);
    chk("ur_prime_lane3", s[3], 32'h11);
    mid();
    chk("ur_cnt0", {30'd0, ucnt}, 32'd0);
    chk("ur_err0", {31'd0, err},  32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      out_ready = 1'b1;
      mid();
      chk("ur_pull_valid", {31'd0, out_valid}, 32'd0);
      chk("ur_pull_data",  out_data, 32'd0);
      tick();
      out_ready = 1'b0;
      mid();
      chk($sformatf("ur_err_pulse%0d", k), {31'd0, err}, 32'd1);
      chk($sformatf("ur_cnt%0d", k), {30'd0, ucnt}, (k < 3) ? k : 3);
      tick();
      mid();
      chk("ur_err_low", {31'd0, err}, 32'd0);
    end

    // flush after lane 1 of an 8-bit word, then restart cleanly
    tick();
    fl_exp[0] = 32'h11;
    fl_exp[1] = 32'h22;
    send_word(32'h44332211);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      mid();
      if (out_valid) begin
        chk($sformatf("fl_lane%0d", got), out_data, fl_exp[got]);
        got++;
      end
      tick();
    end
    cfg_en    = 1'b0;
    out_ready = 1'b0;
    mid();
    chk("fl_cnt_before", {30'd0, ucnt},     32'd3);
    chk("fl_in_ready",   {31'd0, in_ready}, 32'd0);
    tick();
    mid();
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_out_data",  out_data,           32'd0);
    chk("fl_cnt",       {30'd0, ucnt},      32'd0);
    chk("fl_busy",      {31'd0, busy},      32'd0);
    tick();
    cfg_en = 1'b1;
    send_word(32'h04030201);
    mid();
    chk("re_not_early", {31'd0, out_valid}, 32'd0);
    tick();
    mid();
    chk("re_valid", {31'd0, out_valid}, 32'd1);
    chk("re_first", out_data, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
